// File: rtl/wb_arbiter.sv
// Merges ALU and formatted load results onto one register-file write port; writes are registered (1 cycle after the win).
// Loads queue in a DEPTH-entry FIFO (ld_ready drops when full); the ALU is stalled once it has won STARVE_LIMIT times over a waiting load.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_result,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [4:0]                 ld_rd,
    input  logic [2:0]                 ld_funct3,
    input  logic [1:0]                 ld_addr_lo,
    input  logic [31:0]                ld_data,
    input  logic [4:0]                 hz_rs1,
    input  logic [4:0]                 hz_rs2,
    output logic                       hz_stall,
    output logic                       regWrite,
    output logic [4:0]                 rd,
    output logic [31:0]                writeData,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [SW-1:0]   starve_cnt;
    entry_t          head;
    logic            forced;
    logic            funct3_ok;
    logic            push;
    logic            pop;
    logic            alu_win;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    assign head      = mem[rd_ptr];
    assign forced    = (starve_cnt == SW'(STARVE_LIMIT)) && (fifo_count != '0);
    assign alu_ready = !rst && !forced;
    assign ld_ready  = !rst && (fifo_count < CW'(DEPTH));
    assign funct3_ok = (ld_funct3 == 3'b000) || (ld_funct3 == 3'b100) || (ld_funct3 == 3'b001) ||
                       (ld_funct3 == 3'b101) || (ld_funct3 == 3'b010);
    // Bad funct3 and x0 loads still handshake; they are just never stored.
    assign push      = ld_valid && ld_ready && (ld_rd != 5'd0) && funct3_ok;
    assign alu_win   = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign pop       = !alu_win && (fifo_count != '0);

    always_comb begin
        hz_stall = 1'b0;
        if (regWrite && (((hz_rs1 != 5'd0) && (hz_rs1 == rd)) || ((hz_rs2 != 5'd0) && (hz_rs2 == rd))))
            hz_stall = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < fifo_count) begin
                if (((hz_rs1 != 5'd0) && (hz_rs1 == mem[rd_ptr + PW'(k)].rd)) ||
                    ((hz_rs2 != 5'd0) && (hz_rs2 == mem[rd_ptr + PW'(k)].rd)))
                    hz_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {ld_rd, fmt_load(ld_funct3, ld_addr_lo, ld_data)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
            regWrite   <= 1'b0;
            rd         <= 5'd0;
            writeData  <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (pop || (fifo_count == '0))
                starve_cnt <= '0;
            else if (alu_win && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SW'(1);
            regWrite <= alu_win || pop;
            if (alu_win) begin
                rd        <= alu_rd;
                writeData <= alu_result;
            end else if (pop) begin
                rd        <= head.rd;
                writeData <= head.dat;
            end
        end
    end
endmodule
